// File: rtl/fetch_buffer.sv
// Instruction queue between fetch and decode: holds up to DEPTH {pc, instr, fault}
// entries in program order and presents the oldest to decode.
module fetch_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       fetch_valid_i,
  output logic                       fetch_ready_o,
  input  logic [31:0]                fetch_pc_i,
  input  logic [31:0]                fetch_instr_i,
  output logic                       decode_valid_o,
  input  logic                       decode_ready_i,
  output logic [31:0]                decode_pc_o,
  output logic [31:0]                decode_instr_o,
  output logic                       decode_fault_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];
  logic          fault_mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;

  // No pass-through when full: readiness depends only on registered count.
  assign fetch_ready_o  = ~rst_i & (count != FULL);
  assign decode_valid_o = (count != '0);
  assign push           = fetch_valid_i & fetch_ready_o;
  assign pop            = decode_valid_o & decode_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is intentionally not reset; occupancy alone decides what is visible.
  always_ff @(posedge clk_i) begin
    if (push && !flush_i) begin
      pc_mem[wr_ptr]    <= fetch_pc_i;
      instr_mem[wr_ptr] <= fetch_instr_i;
      fault_mem[wr_ptr] <= (fetch_pc_i[1:0] != 2'b00);
    end
  end

  always_comb begin
    decode_pc_o    = '0;
    decode_instr_o = '0;
    decode_fault_o = 1'b0;
    if (decode_valid_o) begin
      decode_pc_o    = pc_mem[rd_ptr];
      decode_instr_o = instr_mem[rd_ptr];
      decode_fault_o = fault_mem[rd_ptr];
    end
  end

  assign count_o = count;

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed self-checking bench for fetch_buffer with hand-computed expectations.
module tb_fetch_buffer;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        flush_i;
  logic        fetch_valid_i;
  logic        fetch_ready_o;
  logic [31:0] fetch_pc_i;
  logic [31:0] fetch_instr_i;
  logic        decode_valid_o;
  logic        decode_ready_i;
  logic [31:0] decode_pc_o;
  logic [31:0] decode_instr_o;
  logic        decode_fault_o;
  logic [2:0]  count_o;

  int tests_run = 0;
  int tests_failed = 0;

  fetch_buffer #(.DEPTH(4)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .flush_i        (flush_i),
    .fetch_valid_i  (fetch_valid_i),
    .fetch_ready_o  (fetch_ready_o),
    .fetch_pc_i     (fetch_pc_i),
    .fetch_instr_i  (fetch_instr_i),
    .decode_valid_o (decode_valid_o),
    .decode_ready_i (decode_ready_i),
    .decode_pc_o    (decode_pc_o),
    .decode_instr_o (decode_instr_o),
    .decode_fault_o (decode_fault_o),
    .count_o        (count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs are driven and outputs sampled 1ns after it.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_one(input logic [31:0] pc, input logic [31:0] instr);
    fetch_valid_i = 1'b1;
    fetch_pc_i    = pc;
    fetch_instr_i = instr;
    tick();
    fetch_valid_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] drain_pc [4];
    int popped;
    drain_pc[0] = 32'h8000_0004;
    drain_pc[1] = 32'h8000_0008;
    drain_pc[2] = 32'h8000_000C;
    drain_pc[3] = 32'h8000_0010;

    rst_i = 1'b1; flush_i = 1'b0; fetch_valid_i = 1'b0; decode_ready_i = 1'b0;
    fetch_pc_i = '0; fetch_instr_i = '0;
    tick(); tick();
    check_val("rst_count", 32'(count_o), 32'd0);
    check_val("rst_valid", 32'(decode_valid_o), 32'd0);
    check_val("rst_ready", 32'(fetch_ready_o), 32'd0);
    check_val("rst_pc", decode_pc_o, 32'd0);
    rst_i = 1'b0;
    #1;
    check_val("rel_ready", 32'(fetch_ready_o), 32'd1);
    check_val("rel_count", 32'(count_o), 32'd0);

    // single entry
    push_one(32'h8000_0000, 32'h0000_0013);
    check_val("single_valid", 32'(decode_valid_o), 32'd1);
    check_val("single_pc", decode_pc_o, 32'h8000_0000);
    check_val("single_instr", decode_instr_o, 32'h0000_0013);
    check_val("single_fault", 32'(decode_fault_o), 32'd0);
    check_val("single_count", 32'(count_o), 32'd1);
    decode_ready_i = 1'b1;
    tick();
    decode_ready_i = 1'b0;
    check_val("single_drain_count", 32'(count_o), 32'd0);
    check_val("single_drain_pc", decode_pc_o, 32'd0);
    check_val("single_drain_instr", decode_instr_o, 32'd0);

    // fill with decode stalled
    for (int i = 0; i < 4; i++) push_one(32'h8000_0000 + 32'(4 * i), 32'h100 + 32'(i));
    check_val("full_count", 32'(count_o), 32'd4);
    check_val("full_ready", 32'(fetch_ready_o), 32'd0);
    fetch_valid_i = 1'b1; fetch_pc_i = 32'h8000_0010; fetch_instr_i = 32'h104;
    tick();
    check_val("held_count", 32'(count_o), 32'd4);
    check_val("held_head", decode_pc_o, 32'h8000_0000);
    decode_ready_i = 1'b1;
    tick();
    decode_ready_i = 1'b0;
    check_val("full_pop_count", 32'(count_o), 32'd3);
    check_val("full_pop_ready", 32'(fetch_ready_o), 32'd1);
    tick();
    fetch_valid_i = 1'b0;
    check_val("fifth_count", 32'(count_o), 32'd4);
    decode_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_val($sformatf("drain_pc%0d", i), decode_pc_o, drain_pc[i]);
      tick();
    end
    decode_ready_i = 1'b0;
    check_val("drain_empty", 32'(count_o), 32'd0);

    // streaming with wrap-around
    popped = 0;
    fetch_valid_i = 1'b1; decode_ready_i = 1'b1;
    for (int k = 0; k < 20; k++) begin
      fetch_pc_i    = 32'h0000_1000 + 32'(4 * k);
      fetch_instr_i = ~(32'h0000_1000 + 32'(4 * k));
      #1;
      check_val($sformatf("stream_valid%0d", k), 32'(decode_valid_o), (k > 0) ? 32'd1 : 32'd0);
      if (k > 0) begin
        check_val($sformatf("stream_pc%0d", k), decode_pc_o, 32'h0000_1000 + 32'(4 * popped));
        check_val($sformatf("stream_instr%0d", k), decode_instr_o, ~(32'h0000_1000 + 32'(4 * popped)));
        popped++;
      end
      tick();
      check_val($sformatf("stream_count%0d", k), 32'(count_o), 32'd1);
    end
    fetch_valid_i = 1'b0;
    check_val("stream_last_pc", decode_pc_o, 32'h0000_1000 + 32'(4 * popped));
    popped++;
    tick();
    decode_ready_i = 1'b0;
    check_val("stream_popped", 32'(popped), 32'd20);
    check_val("stream_end_count", 32'(count_o), 32'd0);

    // flush with simultaneous push/pop
    for (int i = 0; i < 3; i++) push_one(32'h0000_3000 + 32'(4 * i), 32'h77);
    check_val("preflush_count", 32'(count_o), 32'd3);
    flush_i = 1'b1; fetch_valid_i = 1'b1; decode_ready_i = 1'b1;
    fetch_pc_i = 32'hDEAD_0000; fetch_instr_i = 32'hDEAD_BEEF;
    tick();
    flush_i = 1'b0; fetch_valid_i = 1'b0; decode_ready_i = 1'b0;
    check_val("flush_count", 32'(count_o), 32'd0);
    check_val("flush_valid", 32'(decode_valid_o), 32'd0);
    check_val("flush_pc", decode_pc_o, 32'd0);
    push_one(32'h0000_2000, 32'h55);
    check_val("postflush_count", 32'(count_o), 32'd1);
    check_val("postflush_pc", decode_pc_o, 32'h0000_2000);
    check_val("postflush_instr", decode_instr_o, 32'h55);
    decode_ready_i = 1'b1;
    tick();
    decode_ready_i = 1'b0;

    // misaligned PC
    push_one(32'h8000_0002, 32'h13);
    push_one(32'h8000_0004, 32'h14);
    check_val("mis_count", 32'(count_o), 32'd2);
    check_val("mis_pc", decode_pc_o, 32'h8000_0002);
    check_val("mis_fault", 32'(decode_fault_o), 32'd1);
    decode_ready_i = 1'b1;
    tick();
    check_val("aligned_pc", decode_pc_o, 32'h8000_0004);
    check_val("aligned_fault", 32'(decode_fault_o), 32'd0);
    tick();
    decode_ready_i = 1'b0;
    check_val("mis_drain_count", 32'(count_o), 32'd0);

    // reset mid-operation
    push_one(32'h0000_4000, 32'h1);
    push_one(32'h0000_4004, 32'h2);
    check_val("prerst_count", 32'(count_o), 32'd2);
    rst_i = 1'b1; fetch_valid_i = 1'b1; fetch_pc_i = 32'h0000_4008;
    #1;
    check_val("midrst_ready", 32'(fetch_ready_o), 32'd0);
    tick();
    rst_i = 1'b0; fetch_valid_i = 1'b0;
    #1;
    check_val("postrst_count", 32'(count_o), 32'd0);
    check_val("postrst_valid", 32'(decode_valid_o), 32'd0);
    check_val("postrst_ready", 32'(fetch_ready_o), 32'd1);
    check_val("postrst_pc", decode_pc_o, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
